// File: rtl/operand_fetch_regfile.sv
// Register file with two registered read ports, one write port and write-to-read bypass.
// Feeds the rotate stage with a one-cycle operand-fetch latency.
module operand_fetch_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_live_c;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] b_c;

    // Writes to register 0 are dropped, so they never hit the bypass either.
    assign wr_live_c = wr_en && (wr_addr != '0);

    // Per-port read mux: r0 is hardwired zero, a same-cycle write wins over stored data.
    always_comb begin
        a_c = '0;
        b_c = '0;
        if (ra_addr != '0) begin
            a_c = (wr_live_c && (wr_addr == ra_addr)) ? wr_data : regs[ra_addr];
        end
        if (rb_addr != '0) begin
            b_c = (wr_live_c && (wr_addr == rb_addr)) ? wr_data : regs[rb_addr];
        end
    end

    // Storage and operand registers; reset drops any fetch in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
        end else begin
            if (wr_live_c) begin
                regs[wr_addr] <= wr_data;
            end
            op_valid <= rd_valid;
            if (rd_valid) begin
                op_a <= a_c;
                op_b <= b_c;
            end
        end
    end

endmodule
